systolic_sequencer: RTL

//  Sequences one NxN matrix multiply C=A*B on the output-stationary systolic array.
//  - Buffers A and B, loaded element-by-element over a valid/ready port.
//  - On start: clears the array, then drives skewed rows of A (left edge) and columns of B (top edge).
//  - After a drain window, captures all N*N accumulators and offers them on a valid/ready result port.

---
 rtl/systolic_pkg.sv | 29 ++
 rtl/systolic_skew_gen.sv | 30 +++
 rtl/systolic_sequencer.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/systolic_pkg.sv
`default_nettype none
// ============================================================================
// Module   : systolic_pkg
// Brief    : Shared state encoding, default sizes and helpers for the
//            systolic matrix-multiply sequencer.
// Revision : 1.0
// ============================================================================
package systolic_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      CLEAR   = 3'd1,
      FEED    = 3'd2,
      DRAIN   = 3'd3,
      CAPTURE = 3'd4,
      RESULT  = 3'd5
   } seq_state_e;

   localparam int DEF_N          = 3;
   localparam int DEF_DATA_WIDTH = 8;
   localparam int DEF_ACC_WIDTH  = 32;

   // Skewed feed of an n x n operand pair spans 3n-2 cycles.
   function automatic int feed_cycles(input int n);
      return 3 * n - 2;
   endfunction

endpackage
`default_nettype wire

// File: rtl/systolic_skew_gen.sv
`default_nettype none
// ============================================================================
// Module   : systolic_skew_gen
// Brief    : Maps feed step k and a lane number to the operand buffer index
//            (k - lane) plus a flag saying whether that index is in range.
// Revision : 1.0
// ============================================================================
module systolic_skew_gen
   import systolic_pkg::*;
#(
   parameter int N    = DEF_N,
   parameter int KW   = 3,
   parameter int LANE = 0
) (
   input  logic [KW-1:0]        k,
   output logic [$clog2(N)-1:0] idx,
   output logic                 in_range
);

   localparam logic [KW-1:0] c_lane = KW'(LANE);
   localparam logic [KW-1:0] c_n    = KW'(N);

   logic [KW-1:0] w_diff;

   assign w_diff   = k - c_lane;
   assign in_range = (k >= c_lane) && (w_diff < c_n);
   assign idx      = w_diff[$clog2(N)-1:0];

endmodule
`default_nettype wire

// File: rtl/systolic_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : systolic_sequencer
// Brief    : Buffers A/B, feeds them skewed into an output-stationary array,
//            captures the accumulators and offers them on a result port.
//            Define SYSTOLIC_SEQ_STALL_EN to add a FEED/DRAIN stall input.
// Revision : 1.0
// ============================================================================
module systolic_sequencer
   import systolic_pkg::*;
#(
   parameter int N          = DEF_N,
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int ACC_WIDTH  = DEF_ACC_WIDTH,
   parameter int DRAIN_CYC  = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       ld_valid,
   output logic                       ld_ready,
   input  logic                       ld_sel,
   input  logic [$clog2(N)-1:0]       ld_row,
   input  logic [$clog2(N)-1:0]       ld_col,
   input  logic [DATA_WIDTH-1:0]      ld_data,
   input  logic                       start,
`ifdef SYSTOLIC_SEQ_STALL_EN
   input  logic                       stall,
`endif
   output logic                       busy,
   output logic                       done,
   output logic                       arr_clr,
   output logic                       arr_en,
   output logic [N*DATA_WIDTH-1:0]    arr_left,
   output logic [N*DATA_WIDTH-1:0]    arr_top,
   input  logic [N*N*ACC_WIDTH-1:0]   arr_acc,
   output logic                       res_valid,
   input  logic                       res_ready,
   output logic [N*N*ACC_WIDTH-1:0]   res_data
);

   localparam int DW  = DATA_WIDTH;
   localparam int IW  = $clog2(N);
   localparam int KW  = $clog2(3 * N - 1);
   localparam int DCW = $clog2(DRAIN_CYC + 1);

   localparam logic [KW-1:0]  c_last_k = KW'(feed_cycles(N) - 1);
   localparam logic [DCW-1:0] c_last_d = DCW'(DRAIN_CYC - 1);
   localparam logic [IW:0]    c_n_ld   = (IW + 1)'(N);

   seq_state_e                 r_state;
   logic [KW-1:0]              r_k;
   logic [DCW-1:0]             r_dcnt;
   logic                       r_ld_ready;
   logic                       r_busy;
   logic                       r_arr_clr;
   logic                       r_arr_en;
   logic                       r_res_valid;
   logic [N*DW-1:0]            r_arr_left;
   logic [N*DW-1:0]            r_arr_top;
   logic [N*N*ACC_WIDTH-1:0]   r_res_data;
   logic [DW-1:0]              r_a [N][N];
   logic [DW-1:0]              r_b [N][N];

   logic                       w_stall;
   logic                       w_ld_we;
   logic [KW-1:0]              w_k_feed;
   logic [N*DW-1:0]            w_left;
   logic [N*DW-1:0]            w_top;

`ifdef SYSTOLIC_SEQ_STALL_EN
   assign w_stall = stall && ((r_state == FEED) || (r_state == DRAIN));
`else
   assign w_stall = 1'b0;
`endif

   assign w_ld_we  = ld_valid && r_ld_ready &&
                     ({1'b0, ld_row} < c_n_ld) && ({1'b0, ld_col} < c_n_ld);

   // Operands are computed for the step about to be presented: 0 when leaving CLEAR.
   assign w_k_feed = (r_state == FEED) ? r_k + KW'(1) : '0;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
               r_a[i][j] <= '0;
               r_b[i][j] <= '0;
            end
         end
      end else if (w_ld_we) begin
         if (ld_sel) r_b[ld_row][ld_col] <= ld_data;
         else        r_a[ld_row][ld_col] <= ld_data;
      end
   end

   for (genvar g = 0; g < N; g++) begin : g_lane
      logic [IW-1:0] w_a_col;
      logic [IW-1:0] w_b_row;
      logic          w_a_ok;
      logic          w_b_ok;

      systolic_skew_gen #(.N(N), .KW(KW), .LANE(g)) u_left (
         .k        (w_k_feed),
         .idx      (w_a_col),
         .in_range (w_a_ok)
      );

      systolic_skew_gen #(.N(N), .KW(KW), .LANE(g)) u_top (
         .k        (w_k_feed),
         .idx      (w_b_row),
         .in_range (w_b_ok)
      );

      assign w_left[g*DW +: DW] = w_a_ok ? r_a[g][w_a_col] : '0;
      assign w_top[g*DW +: DW]  = w_b_ok ? r_b[w_b_row][g] : '0;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= IDLE;
         r_k         <= '0;
         r_dcnt      <= '0;
         r_ld_ready  <= 1'b0;
         r_busy      <= 1'b0;
         r_arr_clr   <= 1'b0;
         r_arr_en    <= 1'b0;
         r_res_valid <= 1'b0;
         r_arr_left  <= '0;
         r_arr_top   <= '0;
         r_res_data  <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_state    <= CLEAR;
                  r_arr_clr  <= 1'b1;
                  r_busy     <= 1'b1;
                  r_ld_ready <= 1'b0;
               end else begin
                  r_ld_ready <= 1'b1;
               end
            end
            CLEAR: begin
               r_state    <= FEED;
               r_arr_clr  <= 1'b0;
               r_arr_en   <= 1'b1;
               r_k        <= '0;
               r_arr_left <= w_left;
               r_arr_top  <= w_top;
            end
            FEED: begin
               if (!w_stall) begin
                  if (r_k == c_last_k) begin
                     r_state    <= DRAIN;
                     r_dcnt     <= '0;
                     r_arr_left <= '0;
                     r_arr_top  <= '0;
                  end else begin
                     r_k        <= w_k_feed;
                     r_arr_left <= w_left;
                     r_arr_top  <= w_top;
                  end
               end
            end
            DRAIN: begin
               if (!w_stall) begin
                  if (r_dcnt == c_last_d) begin
                     r_state  <= CAPTURE;
                     r_arr_en <= 1'b0;
                  end else begin
                     r_dcnt <= r_dcnt + DCW'(1);
                  end
               end
            end
            CAPTURE: begin
               r_res_data  <= arr_acc;
               r_res_valid <= 1'b1;
               r_state     <= RESULT;
            end
            RESULT: begin
               if (res_ready) begin
                  r_state     <= IDLE;
                  r_res_valid <= 1'b0;
                  r_busy      <= 1'b0;
                  r_ld_ready  <= 1'b1;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   // A stall must gate the array in the very cycle it is raised.
   assign arr_en    = r_arr_en && !w_stall;
   assign ld_ready  = r_ld_ready;
   assign busy      = r_busy;
   assign done      = r_res_valid && res_ready;
   assign arr_clr   = r_arr_clr;
   assign arr_left  = r_arr_left;
   assign arr_top   = r_arr_top;
   assign res_valid = r_res_valid;
   assign res_data  = r_res_data;

endmodule
`default_nettype wire
